// File: rtl/gfx_linebuf_if.sv
// gfx_linebuf_if: clock enables, source pixel stream and HDMI-side outputs of gfx_linebuf.
interface gfx_linebuf_if;
  logic        i_EMU_CLK6MPCEN_n;
  logic        i_EMU_CLK27MPCEN_n;
  logic        i_DE;
  logic        i_SOF;
  logic        i_EOL;
  logic [15:0] i_GFX_VIDEO;
  logic [7:0]  o_HDMI_R;
  logic [7:0]  o_HDMI_G;
  logic [7:0]  o_HDMI_B;
  logic        o_HDMI_HSYNC;
  logic        o_HDMI_VSYNC;
  logic        o_HDMI_DE;
  logic        o_OVERRUN;

  modport master (
    output i_EMU_CLK6MPCEN_n, i_EMU_CLK27MPCEN_n, i_DE, i_SOF, i_EOL, i_GFX_VIDEO,
    input  o_HDMI_R, o_HDMI_G, o_HDMI_B, o_HDMI_HSYNC, o_HDMI_VSYNC, o_HDMI_DE, o_OVERRUN
  );

  modport slave (
    input  i_EMU_CLK6MPCEN_n, i_EMU_CLK27MPCEN_n, i_DE, i_SOF, i_EOL, i_GFX_VIDEO,
    output o_HDMI_R, o_HDMI_G, o_HDMI_B, o_HDMI_HSYNC, o_HDMI_VSYNC, o_HDMI_DE, o_OVERRUN
  );
endinterface

// File: rtl/gfx_linebuf.sv
// gfx_linebuf: captures RGB555 lines into a two-bank buffer and replays each line twice,
// pixel-doubled, on a 720x480p raster. GFX_LINEBUF_SCANLINE_EN halves odd window rows.
module gfx_linebuf #(
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 224,
  parameter int H_OFS    = (720 - 2 * H_ACTIVE) / 2,
  parameter int V_OFS    = (480 - 2 * V_ACTIVE) / 2
) (
  input logic          i_EMU_MCLK,
  input logic          i_MRST,
  gfx_linebuf_if.slave bus
);
  localparam int AW  = $clog2(H_ACTIVE);
  localparam int AW1 = AW + 1;
  localparam int WPW = $clog2(H_ACTIVE + 1);
  localparam logic [WPW-1:0] WP_FULL = WPW'(H_ACTIVE);
  localparam logic [AW:0]    BANK1   = AW1'(H_ACTIVE);
  localparam logic [9:0]     H_LAST  = 10'd857;
  localparam logic [9:0]     V_LAST  = 10'd524;
  localparam logic [9:0]     HW_LO   = 10'(H_OFS);
  localparam logic [9:0]     HW_HI   = 10'(H_OFS + 2 * H_ACTIVE);
  localparam logic [9:0]     VW_LO   = 10'(V_OFS);
  localparam logic [9:0]     VW_HI   = 10'(V_OFS + 2 * V_ACTIVE);

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] shade(input logic [7:0] c8, input logic dim);
    return dim ? {1'b0, c8[7:1]} : c8;
  endfunction

  function automatic logic [AW:0] ram_addr(input logic bank, input logic [AW-1:0] a);
    return bank ? BANK1 + {1'b0, a} : {1'b0, a};
  endfunction

  logic           ce6, ce27;
  logic [14:0]    mem [2*H_ACTIVE];
  logic [WPW-1:0] wp, wp_inc;
  logic           wb, ready, rb, sof_pend, overrun, wr_en;
  logic [9:0]     hc, vc;
  logic           hc_wrap, hwin, vwin, row_odd, rb_latch, rb_cur, dim;
  logic [AW-1:0]  rd_addr;
  logic [14:0]    pix_p1;
  logic           vld_p1, hs_p1, vs_p1, win_p1, dim_p1;
  logic           vld_p2, hs_p2, vs_p2;
  logic [7:0]     r_p2, g_p2, b_p2;
  logic           unused_msb;

  assign ce6        = ~bus.i_EMU_CLK6MPCEN_n;
  assign ce27       = ~bus.i_EMU_CLK27MPCEN_n;
  assign unused_msb = bus.i_GFX_VIDEO[15];
  assign wr_en      = ce6 && bus.i_DE && (wp < WP_FULL);
  assign wp_inc     = wr_en ? wp + 1'b1 : wp;

  assign hc_wrap  = (hc == H_LAST);
  assign hwin     = (hc >= HW_LO) && (hc < HW_HI);
  assign vwin     = (vc >= VW_LO) && (vc < VW_HI);
  assign row_odd  = vc[0] ^ VW_LO[0];
  // The first row of each pair picks up the newest completed line; the odd row reuses it.
  assign rb_latch = (hc == 10'd0) && vwin && !row_odd;
  assign rb_cur   = rb_latch ? ready : rb;
  assign rd_addr  = AW'((hc - HW_LO) >> 1);

`ifdef GFX_LINEBUF_SCANLINE_EN
  assign dim = row_odd;
`else
  assign dim = 1'b0;
`endif

  always_ff @(posedge i_EMU_MCLK) begin
    if (wr_en) mem[ram_addr(wb, wp[AW-1:0])] <= bus.i_GFX_VIDEO[14:0];
  end

  // EOL is evaluated after this cycle's store, then SOF overrides the pointer.
  always_ff @(posedge i_EMU_MCLK or posedge i_MRST) begin
    if (i_MRST) begin
      wp       <= '0;
      wb       <= 1'b0;
      ready    <= 1'b1;
      sof_pend <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (ce6) begin
        wp <= wp_inc;
        if (bus.i_DE && (wp == WP_FULL)) overrun <= 1'b1;
        if (bus.i_EOL && (wp_inc != '0)) begin
          wb    <= ~wb;
          ready <= wb;
          wp    <= '0;
        end
        if (bus.i_SOF) wp <= '0;
      end
      if (ce27 && hc_wrap && sof_pend) sof_pend <= 1'b0;
      if (ce6 && bus.i_SOF)            sof_pend <= 1'b1;
    end
  end

  // Stage p1: buffer read
  always_ff @(posedge i_EMU_MCLK) begin
    if (ce27) pix_p1 <= mem[ram_addr(rb_cur, rd_addr)];
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_MRST) begin
    if (i_MRST) begin
      hc     <= '0;
      vc     <= '0;
      rb     <= 1'b1;
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      win_p1 <= 1'b0;
      dim_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      r_p2   <= '0;
      g_p2   <= '0;
      b_p2   <= '0;
    end else if (ce27) begin
      if (hc_wrap) begin
        hc <= '0;
        if (sof_pend || (vc == V_LAST)) vc <= '0;
        else                            vc <= vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
      if (rb_latch) rb <= ready;
      vld_p1 <= (hc < 10'd720) && (vc < 10'd480);
      hs_p1  <= !((hc >= 10'd736) && (hc <= 10'd797));
      vs_p1  <= !((vc >= 10'd489) && (vc <= 10'd494));
      win_p1 <= hwin && vwin;
      dim_p1 <= dim;
      // Stage p2: colour expansion and output register
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      r_p2   <= win_p1 ? shade(expand5(pix_p1[14:10]), dim_p1) : 8'd0;
      g_p2   <= win_p1 ? shade(expand5(pix_p1[9:5]),   dim_p1) : 8'd0;
      b_p2   <= win_p1 ? shade(expand5(pix_p1[4:0]),   dim_p1) : 8'd0;
    end
  end

  assign bus.o_HDMI_R     = r_p2;
  assign bus.o_HDMI_G     = g_p2;
  assign bus.o_HDMI_B     = b_p2;
  assign bus.o_HDMI_HSYNC = hs_p2;
  assign bus.o_HDMI_VSYNC = vs_p2;
  assign bus.o_HDMI_DE    = vld_p2;
  assign bus.o_OVERRUN    = overrun;
endmodule

// File: tb/tb_gfx_linebuf.sv
// tb_gfx_linebuf: random-enable source/raster stimulus against a behavioural scan-converter model.
module tb_gfx_linebuf;
  localparam int H_ACTIVE = 256;
  localparam int V_ACTIVE = 6;
  localparam int H_OFS    = 104;
  localparam int V_OFS    = 8;
  localparam int H_TOT    = 858;
  localparam int V_TOT    = 525;
`ifdef GFX_LINEBUF_SCANLINE_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif
  localparam logic [26:0] IDLE_OUT = {24'h0, 3'b110};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int unsigned cyc = 0;

  gfx_linebuf_if bus();

  gfx_linebuf #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_OFS(H_OFS), .V_OFS(V_OFS)
  ) dut (
    .i_EMU_MCLK(clk),
    .i_MRST(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  // Enables change on the falling edge: 6 MHz every 4th cycle, 27 MHz with random gaps.
  initial begin
    bus.i_EMU_CLK6MPCEN_n  = 1'b1;
    bus.i_EMU_CLK27MPCEN_n = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      bus.i_EMU_CLK6MPCEN_n  = (cyc % 4 != 0);
      bus.i_EMU_CLK27MPCEN_n = ($urandom_range(7) == 0);
    end
  end

  // Reference model: line buffer banks, raster position and a 2-enable output delay.
  logic [14:0] bank [2][H_ACTIVE];
  int          wp_m, pos_m;
  bit          wb_m, ready_m, rb_m, sofp_m, ovr_m;
  logic [26:0] stg1_m, out_m;

  function automatic logic [7:0] exp8(input logic [4:0] c, input int odd);
    int v;
    v = c * 8 + c / 4;
    if (SCAN && odd != 0) v = v / 2;
    return v[7:0];
  endfunction

  task automatic model_reset();
    wp_m = 0; pos_m = 0; wb_m = 0; ready_m = 1; rb_m = 1; sofp_m = 0; ovr_m = 0;
    stg1_m = IDLE_OUT; out_m = IDLE_OUT;
  endtask

  task automatic rd_step();
    int hc, vc, row;
    logic [14:0] px;
    logic [7:0] r, g, b;
    hc = pos_m % H_TOT;
    vc = pos_m / H_TOT;
    row = vc - V_OFS;
    r = 0; g = 0; b = 0;
    if (hc == 0 && row >= 0 && row < 2 * V_ACTIVE && row % 2 == 0) rb_m = ready_m;
    if (hc >= H_OFS && hc < H_OFS + 2 * H_ACTIVE && row >= 0 && row < 2 * V_ACTIVE) begin
      px = bank[rb_m][(hc - H_OFS) / 2];
      r = exp8(px[14:10], row % 2);
      g = exp8(px[9:5], row % 2);
      b = exp8(px[4:0], row % 2);
    end
    out_m  = stg1_m;
    stg1_m = {r, g, b, !(hc >= 736 && hc <= 797), !(vc >= 489 && vc <= 494),
              (hc < 720 && vc < 480)};
    if (hc == H_TOT - 1 && sofp_m) begin
      pos_m = 0;
      sofp_m = 0;
    end else begin
      pos_m = (pos_m + 1) % (H_TOT * V_TOT);
    end
  endtask

  task automatic wr_step(input bit de, input bit sof, input bit eol, input logic [15:0] pix);
    if (de) begin
      if (wp_m < H_ACTIVE) begin
        bank[wb_m][wp_m] = pix[14:0];
        wp_m++;
      end else begin
        ovr_m = 1;
      end
    end
    if (eol && wp_m != 0) begin
      ready_m = wb_m;
      wb_m = !wb_m;
      wp_m = 0;
    end
    if (sof) begin
      wp_m = 0;
      sofp_m = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else begin
        if (!bus.i_EMU_CLK27MPCEN_n) rd_step();
        if (!bus.i_EMU_CLK6MPCEN_n) wr_step(bus.i_DE, bus.i_SOF, bus.i_EOL, bus.i_GFX_VIDEO);
      end
      #1;
      chk("video", {4'h0, bus.o_HDMI_R, bus.o_HDMI_G, bus.o_HDMI_B, bus.o_HDMI_HSYNC,
                    bus.o_HDMI_VSYNC, bus.o_HDMI_DE, bus.o_OVERRUN}, {4'h0, out_m, ovr_m});
    end
  end

  task automatic src(input bit de, input bit sof, input bit eol, input logic [15:0] pix);
    do begin @(negedge clk); #1; end while (bus.i_EMU_CLK6MPCEN_n);
    bus.i_DE = de; bus.i_SOF = sof; bus.i_EOL = eol; bus.i_GFX_VIDEO = pix;
    @(posedge clk); #1;
    bus.i_DE = 1'b0; bus.i_SOF = 1'b0; bus.i_EOL = 1'b0;
  endtask

  task automatic send_line(input int n, input bit ramp);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) src(1'b0, 1'b0, 1'b0, 16'h0);
      src(1'b1, 1'b0, 1'b0, ramp ? 16'(i) : 16'($urandom));
    end
    src(1'b0, 1'b0, 1'b1, 16'h0);
  endtask

  task automatic first_hsync(input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (!bus.i_EMU_CLK27MPCEN_n) cnt++;
      #1;
      if (!bus.o_HDMI_HSYNC) break;
    end
    chk(tag, cnt, 738);
  endtask

  initial begin
    int cnt, hs_lo, de_hi;
    bus.i_DE = 1'b0; bus.i_SOF = 1'b0; bus.i_EOL = 1'b0; bus.i_GFX_VIDEO = 16'h0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_rgb", {bus.o_HDMI_R, bus.o_HDMI_G, bus.o_HDMI_B}, 0);
    chk("rst_sync", {bus.o_HDMI_HSYNC, bus.o_HDMI_VSYNC, bus.o_HDMI_DE}, 3'b110);
    chk("rst_ovr", bus.o_OVERRUN, 0);
    @(negedge clk);
    rst = 1'b0;
    first_hsync("first_hsync_enable");

    cnt = 0; hs_lo = 0; de_hi = 0;
    for (int i = 0; i < 4000 && cnt < H_TOT; i++) begin
      @(posedge clk);
      if (!bus.i_EMU_CLK27MPCEN_n) begin
        cnt++;
        #1;
        if (!bus.o_HDMI_HSYNC) hs_lo++;
        if (bus.o_HDMI_DE) de_hi++;
      end
    end
    chk("line_enables", cnt, H_TOT);
    chk("hsync_low_per_line", hs_lo, 62);
    chk("de_high_per_line", de_hi, 720);

    send_line(H_ACTIVE, 1'b0);
    send_line(H_ACTIVE, 1'b1);
    for (int l = 0; l < 18; l++) send_line($urandom_range(H_ACTIVE), 1'b0);
    chk("ovr_clear", bus.o_OVERRUN, 0);
    send_line(H_ACTIVE + 1, 1'b1);
    chk("ovr_set", bus.o_OVERRUN, 1);

    for (int i = 0; i < 20; i++) src(1'b1, 1'b0, 1'b0, 16'($urandom));
    src(1'b0, 1'b1, 1'b1, 16'h0);
    for (int l = 0; l < 22; l++) send_line($urandom_range(H_ACTIVE), 1'b0);
    chk("ovr_sticky", bus.o_OVERRUN, 1);

    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_rgb", {bus.o_HDMI_R, bus.o_HDMI_G, bus.o_HDMI_B}, 0);
    chk("midrst_sync", {bus.o_HDMI_HSYNC, bus.o_HDMI_VSYNC, bus.o_HDMI_DE}, 3'b110);
    chk("midrst_ovr", bus.o_OVERRUN, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first_hsync("resume_hsync_enable");
    send_line(H_ACTIVE, 1'b1);
    repeat (200) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
